// File: rtl/id_stage_if.sv
// Fetch <-> decode boundary: the IF/ID register contents flowing into decode
// and the stall/flush/redirect controls flowing back to fetch.
interface id_stage_if #(
   parameter int XLEN = 32
);
   // {valid, pc, instr}
   logic [2*XLEN:0] if_id_in;
   logic            stall_out;
   logic            flush_out;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   modport master (
      output if_id_in,
      input  stall_out, flush_out, redirect_valid, redirect_pc
   );

   modport slave (
      input  if_id_in,
      output stall_out, flush_out, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: decodes IF/ID, reads the register file, loads ID/EX,
// and produces the load-use stall and JAL redirect/flush for fetch.
module id_stage #(
   parameter int NUM_REGS = 32,
   parameter int XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   id_stage_if.slave       fe,
   input  logic            stall_in,
   input  logic            ex_flush,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            idex_valid,
   output logic [XLEN-1:0] idex_pc,
   output logic [XLEN-1:0] idex_rs1_data,
   output logic [XLEN-1:0] idex_rs2_data,
   output logic [XLEN-1:0] idex_imm,
   output logic [4:0]      idex_rs1,
   output logic [4:0]      idex_rs2,
   output logic [4:0]      idex_rd,
   output logic [2:0]      idex_funct3,
   output logic [3:0]      idex_alu_op,
   output logic            idex_alu_src_imm,
   output logic            idex_alu_src_pc,
   output logic            idex_mem_read,
   output logic            idex_mem_write,
   output logic            idex_reg_write,
   output logic            idex_is_branch,
   output logic            idex_is_jump,
   output logic            idex_illegal
);
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                          ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                          ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASS_B = 4'd10;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic [3:0]      alu_op;
      logic            alu_src_imm;
      logic            alu_src_pc;
      logic            mem_read;
      logic            mem_write;
      logic            reg_write;
      logic            is_branch;
      logic            is_jump;
      logic            illegal;
   } idex_t;

   idex_t           dec, idex_d, idex_q;
   logic [XLEN-1:0] rf_q [NUM_REGS];

   logic            if_valid;
   logic [XLEN-1:0] if_pc, instr;
   logic [6:0]      opcode;
   logic [4:0]      rd, rs1, rs2;
   logic [2:0]      funct3;
   logic            funct7_b5;
   logic signed [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic            rs1_used, rs2_used, ld_hazard, stall_raw, jal_fire;

   assign if_valid  = fe.if_id_in[2*XLEN];
   assign if_pc     = fe.if_id_in[2*XLEN-1:XLEN];
   assign instr     = fe.if_id_in[XLEN-1:0];
   assign opcode    = instr[6:0];
   assign rd        = instr[11:7];
   assign funct3    = instr[14:12];
   assign rs1       = instr[19:15];
   assign rs2       = instr[24:20];
   assign funct7_b5 = instr[30];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // Write-first: a same-cycle writeback to the source register is returned directly.
   function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
      if (idx == 5'd0)                return '0;
      else if (wb_en && wb_rd == idx) return wb_data;
      else                            return rf_q[idx];
   endfunction

   function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   always_comb begin
      dec          = '0;
      dec.valid    = 1'b1;
      dec.pc       = if_pc;
      dec.rs1_data = rf_read(rs1);
      dec.rs2_data = rf_read(rs2);
      dec.rs1      = rs1;
      dec.rs2      = rs2;
      dec.rd       = rd;
      dec.funct3   = funct3;
      dec.alu_op   = ALU_ADD;
      case (opcode)
         OPC_OP_IMM: begin
            dec.imm         = imm_i;
            dec.alu_src_imm = 1'b1;
            dec.reg_write   = 1'b1;
            dec.alu_op      = alu_sel(funct3, funct7_b5 && funct3 == 3'b101);
         end
         OPC_OP: begin
            dec.reg_write = 1'b1;
            dec.alu_op    = alu_sel(funct3, funct7_b5);
         end
         OPC_LUI: begin
            dec.imm         = imm_u;
            dec.alu_op      = ALU_PASS_B;
            dec.alu_src_imm = 1'b1;
            dec.reg_write   = 1'b1;
         end
         OPC_AUIPC: begin
            dec.imm         = imm_u;
            dec.alu_src_pc  = 1'b1;
            dec.alu_src_imm = 1'b1;
            dec.reg_write   = 1'b1;
         end
         OPC_LOAD: begin
            dec.imm         = imm_i;
            dec.alu_src_imm = 1'b1;
            dec.mem_read    = 1'b1;
            dec.reg_write   = 1'b1;
         end
         OPC_STORE: begin
            dec.imm         = imm_s;
            dec.alu_src_imm = 1'b1;
            dec.mem_write   = 1'b1;
         end
         OPC_BRANCH: begin
            dec.imm       = imm_b;
            dec.alu_op    = ALU_SUB;
            dec.is_branch = 1'b1;
         end
         OPC_JAL: begin
            dec.imm       = imm_j;
            dec.is_jump   = 1'b1;
            dec.reg_write = 1'b1;
         end
         OPC_JALR: begin
            dec.imm         = imm_i;
            dec.alu_src_imm = 1'b1;
            dec.is_jump     = 1'b1;
            dec.reg_write   = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
      if (rd == 5'd0) dec.reg_write = 1'b0;
   end

   assign rs1_used  = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
   assign rs2_used  = (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH);
   assign ld_hazard = if_valid && idex_q.valid && idex_q.mem_read && (idex_q.rd != 5'd0) &&
                      ((rs1_used && rs1 == idex_q.rd) || (rs2_used && rs2 == idex_q.rd));
   assign stall_raw = stall_in || ld_hazard;
   assign jal_fire  = !rst && !ex_flush && !stall_raw && if_valid && opcode == OPC_JAL;

   assign fe.stall_out      = !rst && !ex_flush && stall_raw;
   assign fe.flush_out      = jal_fire;
   assign fe.redirect_valid = jal_fire;
   assign fe.redirect_pc    = if_pc + imm_j;

   always_comb begin
      idex_d = dec;
      if (ex_flush)                    idex_d = '0;
      else if (stall_in)               idex_d = idex_q;
      else if (ld_hazard || !if_valid) idex_d = '0;
   end

   // ID/EX pipeline register
   always_ff @(posedge clk) begin
      if (rst) idex_q <= '0;
      else     idex_q <= idex_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      end else if (wb_en && wb_rd != 5'd0) begin
         rf_q[wb_rd] <= wb_data;
      end
   end

   assign idex_valid       = idex_q.valid;
   assign idex_pc          = idex_q.pc;
   assign idex_rs1_data    = idex_q.rs1_data;
   assign idex_rs2_data    = idex_q.rs2_data;
   assign idex_imm         = idex_q.imm;
   assign idex_rs1         = idex_q.rs1;
   assign idex_rs2         = idex_q.rs2;
   assign idex_rd          = idex_q.rd;
   assign idex_funct3      = idex_q.funct3;
   assign idex_alu_op      = idex_q.alu_op;
   assign idex_alu_src_imm = idex_q.alu_src_imm;
   assign idex_alu_src_pc  = idex_q.alu_src_pc;
   assign idex_mem_read    = idex_q.mem_read;
   assign idex_mem_write   = idex_q.mem_write;
   assign idex_reg_write   = idex_q.reg_write;
   assign idex_is_branch   = idex_q.is_branch;
   assign idex_is_jump     = idex_q.is_jump;
   assign idex_illegal     = idex_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios with literal expectations, then random
// traffic compared every cycle against an instruction-level reference model.
module tb_id_stage;
   logic        clk = 1'b0;
   logic        rst, stall_in, ex_flush, wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        idex_valid, idex_alu_src_imm, idex_alu_src_pc, idex_mem_read, idex_mem_write;
   logic        idex_reg_write, idex_is_branch, idex_is_jump, idex_illegal;
   logic [31:0] idex_pc, idex_rs1_data, idex_rs2_data, idex_imm;
   logic [4:0]  idex_rs1, idex_rs2, idex_rd;
   logic [2:0]  idex_funct3;
   logic [3:0]  idex_alu_op;

   int n_tests = 0;
   int n_fail  = 0;

   id_stage_if #(.XLEN(32)) fe_if ();

   id_stage #(.NUM_REGS(32), .XLEN(32)) dut (
      .clk(clk), .rst(rst), .fe(fe_if), .stall_in(stall_in), .ex_flush(ex_flush),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_rs1_data(idex_rs1_data),
      .idex_rs2_data(idex_rs2_data), .idex_imm(idex_imm), .idex_rs1(idex_rs1),
      .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_funct3(idex_funct3),
      .idex_alu_op(idex_alu_op), .idex_alu_src_imm(idex_alu_src_imm),
      .idex_alu_src_pc(idex_alu_src_pc), .idex_mem_read(idex_mem_read),
      .idex_mem_write(idex_mem_write), .idex_reg_write(idex_reg_write),
      .idex_is_branch(idex_is_branch), .idex_is_jump(idex_is_jump),
      .idex_illegal(idex_illegal)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] OP_IMM = 7'h13, OP = 7'h33, LUI = 7'h37, AUIPC = 7'h17, LOAD = 7'h03,
                          STORE = 7'h23, BRANCH = 7'h63, JAL = 7'h6F, JALR = 7'h67;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc, rs1_data, rs2_data, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  f3;
      logic [3:0]  alu_op;
      logic        src_imm, src_pc, mem_read, mem_write, reg_write, is_branch, is_jump, illegal;
   } idex_m_t;

   idex_m_t     m_q;
   idex_m_t     dut_v;
   logic [31:0] m_regs [32];
   bit          chk_en = 0;

   assign dut_v = {idex_valid, idex_pc, idex_rs1_data, idex_rs2_data, idex_imm, idex_rs1,
                   idex_rs2, idex_rd, idex_funct3, idex_alu_op, idex_alu_src_imm,
                   idex_alu_src_pc, idex_mem_read, idex_mem_write, idex_reg_write,
                   idex_is_branch, idex_is_jump, idex_illegal};

   task automatic chk1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkv(input string name, input idex_m_t act, input idex_m_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (wb_en && wb_rd == a) return wb_data;
      return m_regs[a];
   endfunction

   function automatic logic [31:0] imm_j_of(input logic [31:0] ins);
      logic signed [31:0] si = ins;
      return (32'(si >>> 11) & 32'hFFF0_0000) | (ins & 32'h000F_F000) |
             (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
   endfunction

   function automatic idex_m_t m_decode(input logic [31:0] pc, input logic [31:0] ins);
      idex_m_t r;
      logic signed [31:0] si = ins;
      logic [31:0] imm_i, imm_s, imm_b, imm_u;
      logic [3:0]  tab [8];
      logic [6:0]  o = ins[6:0];
      tab   = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
      imm_i = 32'(si >>> 20);
      imm_s = {imm_i[31:5], ins[11:7]};
      imm_u = ins & 32'hFFFF_F000;
      imm_b = (32'(si >>> 19) & 32'hFFFF_F000) | (32'(ins[7]) << 11) |
              (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      r = '0;
      r.valid = 1'b1; r.pc = pc; r.rs1 = ins[19:15]; r.rs2 = ins[24:20];
      r.rd = ins[11:7]; r.f3 = ins[14:12];
      r.rs1_data = m_read(r.rs1); r.rs2_data = m_read(r.rs2);
      if (o == OP_IMM || o == OP) begin
         r.alu_op = tab[r.f3];
         if (ins[30] && r.f3 == 3'd5) r.alu_op = 4'd7;
         if (ins[30] && r.f3 == 3'd0 && o == OP) r.alu_op = 4'd1;
         r.reg_write = 1'b1;
         if (o == OP_IMM) begin r.imm = imm_i; r.src_imm = 1'b1; end
      end else if (o == LUI) begin
         r.imm = imm_u; r.alu_op = 4'd10; r.src_imm = 1'b1; r.reg_write = 1'b1;
      end else if (o == AUIPC) begin
         r.imm = imm_u; r.src_pc = 1'b1; r.src_imm = 1'b1; r.reg_write = 1'b1;
      end else if (o == LOAD) begin
         r.imm = imm_i; r.src_imm = 1'b1; r.mem_read = 1'b1; r.reg_write = 1'b1;
      end else if (o == STORE) begin
         r.imm = imm_s; r.src_imm = 1'b1; r.mem_write = 1'b1;
      end else if (o == BRANCH) begin
         r.imm = imm_b; r.alu_op = 4'd1; r.is_branch = 1'b1;
      end else if (o == JAL) begin
         r.imm = imm_j_of(ins); r.is_jump = 1'b1; r.reg_write = 1'b1;
      end else if (o == JALR) begin
         r.imm = imm_i; r.src_imm = 1'b1; r.is_jump = 1'b1; r.reg_write = 1'b1;
      end else begin
         r.illegal = 1'b1;
      end
      if (r.rd == 5'd0) r.reg_write = 1'b0;
      return r;
   endfunction

   function automatic bit m_haz();
      logic [31:0] ins = fe_if.if_id_in[31:0];
      logic [6:0]  o   = ins[6:0];
      bit u1 = !(o == LUI || o == AUIPC || o == JAL);
      bit u2 = (o == OP || o == STORE || o == BRANCH);
      return fe_if.if_id_in[64] && m_q.valid && m_q.mem_read && m_q.rd != 5'd0 &&
             ((u1 && ins[19:15] == m_q.rd) || (u2 && ins[24:20] == m_q.rd));
   endfunction

   always @(posedge clk) begin
      idex_m_t nxt;
      if (rst) begin
         m_q = '0;
         for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      end else begin
         if (ex_flush)                            nxt = '0;
         else if (stall_in)                       nxt = m_q;
         else if (!fe_if.if_id_in[64] || m_haz()) nxt = '0;
         else nxt = m_decode(fe_if.if_id_in[63:32], fe_if.if_id_in[31:0]);
         m_q = nxt;
         if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
      end
      chk_en = 1;
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         bit st, rv;
         st = !rst && !ex_flush && (stall_in || m_haz());
         rv = !rst && !ex_flush && !(stall_in || m_haz()) && fe_if.if_id_in[64] &&
              fe_if.if_id_in[6:0] == JAL;
         chk1("stall_out", fe_if.stall_out, st);
         chk1("flush_out", fe_if.flush_out, rv);
         chk1("redirect_valid", fe_if.redirect_valid, rv);
         if (rv) chk32("redirect_pc", fe_if.redirect_pc,
                       fe_if.if_id_in[63:32] + imm_j_of(fe_if.if_id_in[31:0]));
         chkv("idex_fields", dut_v, m_q);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_if(input logic v, input logic [31:0] pc, input logic [31:0] ins);
      fe_if.if_id_in = {v, pc, ins};
   endtask

   initial begin
      rst = 1'b1; stall_in = 1'b0; ex_flush = 1'b0;
      wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
      set_if(1'b0, 32'h0, 32'h0);
      tick(); tick();
      rst = 1'b0;
      tick();
      chk1("rst_idex_valid", idex_valid, 1'b0);
      chk1("rst_stall_out", fe_if.stall_out, 1'b0);
      chk1("rst_redirect", fe_if.redirect_valid, 1'b0);
      chk1("rst_reg_write", idex_reg_write, 1'b0);

      set_if(1'b1, 32'h0, 32'h008381B3);      // ADD x3,x7,x8
      tick();
      chk32("rst_regs_rs1", idex_rs1_data, 32'h0);
      chk32("rst_regs_rs2", idex_rs2_data, 32'h0);

      set_if(1'b1, 32'h4, 32'h00100093);      // ADDI x1,x0,1
      tick();
      chk1("addi_valid", idex_valid, 1'b1);
      chk32("addi_pc", idex_pc, 32'h4);
      chk32("addi_rd", 32'(idex_rd), 32'd1);
      chk32("addi_imm", idex_imm, 32'd1);
      chk32("addi_alu_op", 32'(idex_alu_op), 32'd0);
      chk1("addi_src_imm", idex_alu_src_imm, 1'b1);
      chk1("addi_reg_write", idex_reg_write, 1'b1);
      chk32("addi_rs1_data", idex_rs1_data, 32'h0);
      chk32("model_addi_imm", m_q.imm, 32'd1);

      set_if(1'b1, 32'h8, 32'h002081B3);      // ADD x3,x1,x2 with same-cycle x1 write
      wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
      tick();
      chk32("bypass_rs1", idex_rs1_data, 32'h55);
      set_if(1'b1, 32'hC, 32'h000001B3);      // ADD x3,x0,x0 while writing x0
      wb_rd = 5'd0; wb_data = 32'hFF;
      tick();
      chk32("x0_bypass", idex_rs1_data, 32'h0);
      wb_en = 1'b0;
      set_if(1'b1, 32'hC, 32'h000081B3);      // ADD x3,x1,x0
      tick();
      chk32("x1_stored", idex_rs1_data, 32'h55);
      chk32("x0_read", idex_rs2_data, 32'h0);

      set_if(1'b1, 32'h10, 32'h00002283);     // LW x5,0(x0)
      tick();
      set_if(1'b1, 32'h14, 32'h00528333);     // ADD x6,x5,x5
      #1;
      chk1("lu_stall", fe_if.stall_out, 1'b1);
      tick();
      chk1("lu_bubble", idex_valid, 1'b0);
      #1;
      chk1("lu_stall_once", fe_if.stall_out, 1'b0);
      tick();
      chk1("lu_add_valid", idex_valid, 1'b1);
      chk32("lu_add_rs1", 32'(idex_rs1), 32'd5);
      chk32("lu_add_rs2", 32'(idex_rs2), 32'd5);

      set_if(1'b1, 32'h10, 32'h008000EF);     // JAL x1,+8
      #1;
      chk1("jal_redirect", fe_if.redirect_valid, 1'b1);
      chk32("jal_target", fe_if.redirect_pc, 32'h18);
      chk1("jal_flush", fe_if.flush_out, 1'b1);
      tick();
      set_if(1'b0, 32'h0, 32'h0);
      #1;
      chk1("jal_one_cycle", fe_if.redirect_valid, 1'b0);
      chk1("jal_is_jump", idex_is_jump, 1'b1);
      chk32("jal_rd", 32'(idex_rd), 32'd1);
      chk32("jal_imm", idex_imm, 32'd8);
      chk32("model_jal_imm", m_q.imm, 32'd8);

      set_if(1'b1, 32'h10, 32'h008000EF);
      ex_flush = 1'b1;
      #1;
      chk1("xf_no_redirect", fe_if.redirect_valid, 1'b0);
      chk1("xf_no_flush", fe_if.flush_out, 1'b0);
      tick();
      ex_flush = 1'b0;
      chk1("xf_bubble", idex_valid, 1'b0);

      set_if(1'b1, 32'h20, 32'h00100093);
      tick();
      stall_in = 1'b1;
      set_if(1'b1, 32'h24, 32'h00528333);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk1("stall_out_held", fe_if.stall_out, 1'b1);
         tick();
         chk32("stall_pc_held", idex_pc, 32'h20);
      end
      stall_in = 1'b0;

      set_if(1'b1, 32'h30, 32'h0000007F);
      tick();
      chk1("illegal_flag", idex_illegal, 1'b1);
      chk1("illegal_no_wr", idex_reg_write, 1'b0);
      chk1("illegal_valid", idex_valid, 1'b1);

      for (int n = 0; n < 3000; n++) begin
         logic [6:0] opc_tab [9];
         logic [6:0] opc;
         int         pick;
         opc_tab = '{OP_IMM, OP, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR};
         pick = $urandom_range(0, 11);
         if (pick < 9)       opc = opc_tab[pick];
         else if (pick < 11) opc = LOAD;
         else                opc = 7'($urandom);
         rst      = ($urandom_range(0, 199) == 0);
         ex_flush = ($urandom_range(0, 15) == 0);
         stall_in = ($urandom_range(0, 7) == 0);
         wb_en    = ($urandom_range(0, 1) == 1);
         wb_rd    = 5'($urandom_range(0, 7));
         wb_data  = $urandom;
         set_if($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC,
                {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 3'($urandom), 5'($urandom_range(0, 7)), opc});
         tick();
      end
      rst = 1'b0; ex_flush = 1'b0; stall_in = 1'b0; wb_en = 1'b0;
      set_if(1'b0, 32'h0, 32'h0);
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage: consumer side of the IF/ID interface. Takes `if_id_t` (valid, pc, instr) from the fetch pipeline register and decodes the RV32I subset.
- Reads an internal 32x32 register file and registers the result into the ID/EX pipeline register.
- Generates the stall, flush and redirect signals that drive fetch: load-use stall and JAL redirect.

Parameters:
- NUM_REGS, 32, number of architectural registers; x0 is hardwired to zero.
- XLEN, 32, data and PC width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_id_in  in  $bits(if_id_t)  IF/ID register contents {valid, pc[31:0], instr[31:0]}
- stall_in  in  1  back-end stall; freezes ID/EX
- ex_flush  in  1  EX-resolved branch mispredict; kills ID/EX contents and suppresses ID redirect
- wb_en  in  1  register-file write enable
- wb_rd  in  5  write address
- wb_data  in  32  write data
- stall_out  out  1  to fetch stall (holds PC and IF/ID)
- flush_out  out  1  to fetch flush (clears IF/ID)
- redirect_valid  out  1  to fetch
- redirect_pc  out  32  to fetch
- idex_valid, idex_pc[31:0], idex_rs1_data[31:0], idex_rs2_data[31:0], idex_imm[31:0]  out  ID/EX data fields
- idex_rs1[4:0], idex_rs2[4:0], idex_rd[4:0], idex_funct3[2:0]  out  ID/EX register-index and function fields
- idex_alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
- idex_alu_src_imm, idex_alu_src_pc, idex_mem_read, idex_mem_write, idex_reg_write, idex_is_branch, idex_is_jump, idex_illegal  out  1 each  ID/EX control flags

Behaviour:
- **Reset.** Synchronous. All ID/EX outputs are 0, and stall_out, flush_out and redirect_valid are 0. Register file contents are 0 after reset. Reset asserted mid-stall or mid-redirect wins the same edge.
- **Decoded opcodes.** OP-IMM, OP, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR. Anything else sets illegal=1 with reg_write, mem_read and mem_write forced to 0, valid unchanged.
- **Immediates.** I/S/B/U/J formats, sign-extended to 32 bits; B and J have bit0 = 0.
- **ALU selection.**
  - SUB and SRA are selected by funct7[5] (for OP, and for shifts only in OP-IMM).
  - LUI uses PASS_B with src_imm = 1.
  - AUIPC uses ADD with src_pc = 1 and src_imm = 1.
  - JAL and JALR set is_jump and reg_write.
- **rd handling.** rd = 0 forces reg_write = 0.
- **Register file.** Combinational reads; write on the clk edge when wb_en && wb_rd != 0.
  - Write-first bypass: if wb_en && wb_rd == rs && rs != 0 in the decode cycle, the read returns wb_data.
  - Reads of x0 always return 0.
- **Latency.** One cycle: the ID/EX fields reflect the IF/ID contents sampled at the previous edge.
- **Load-use hazard.** Condition: idex_valid && idex_mem_read && idex_rd != 0 && (idex_rd == rs1 used || idex_rd == rs2 used), with if_id_in.valid.
  - rs2 counts as used only for OP, STORE and BRANCH.
  - rs1 counts as used for all opcodes except LUI, AUIPC and JAL.
  - Response (combinational): stall_out = 1, and ID/EX loads a bubble (valid = 0, all control flags 0) at the next edge.
  - Exactly one bubble cycle per hazard.
- **stall_in.** ID/EX holds its value, stall_out = 1 (OR of stall_in and hazard), and no redirect is issued.
- **JAL.** When if_id_in.valid, opcode is JAL, no stall, and no ex_flush:
  - redirect_valid = 1 and redirect_pc = pc + immJ (mod 2^32), combinational, one cycle.
  - flush_out = 1 that same cycle.
  - The JAL itself enters ID/EX with valid = 1 (for the rd = pc+4 writeback).
- **ex_flush.**
  - Overrides everything except rst.
  - ID/EX loads a bubble at the next edge, even if stall_in = 1.
  - redirect_valid = 0 and flush_out = 0 from ID.
- **Invalid input.** if_id_in.valid = 0 produces a bubble.
- **Priority:** rst > ex_flush > stall_in > load-use hazard > JAL redirect > normal.
- **Scope.** JALR, BRANCH and EX forwarding are handled in EX; ID only decodes them.

Test Plan:
- rst high 2 cycles, then release with if_id_in.valid = 0 → all outputs 0; reading any register gives 0.
- IF/ID = {1, 0x4, 0x00100093} (ADDI x1,x0,1) → next cycle idex_valid = 1, pc = 0x4, rd = 1, imm = 1, alu_op = 0, src_imm = 1, reg_write = 1, rs1_data = 0.
- wb_en = 1, wb_rd = 1, wb_data = 0x55 in the same cycle as IF/ID ADD x3,x1,x2 (0x002081B3) → idex_rs1_data = 0x55. A write to x0 with 0xFF → a later read of x0 returns 0.
- LW x5,0(x0) (0x00002283) followed by ADD x6,x5,x5 (0x00528333):
  - stall_out = 1 for exactly 1 cycle and ID/EX gets a bubble.
  - The ADD then issues with rs1 = rs2 = 5.
- JAL x1,+8 (0x008000EF) at pc 0x10:
  - redirect_valid = 1, redirect_pc = 0x18, flush_out = 1 for 1 cycle.
  - Next cycle idex_is_jump = 1, rd = 1, imm = 8.
- JAL with ex_flush = 1 in the same cycle → redirect_valid = 0, next idex_valid = 0.
- stall_in = 1 for 3 cycles → ID/EX unchanged and stall_out = 1 throughout.
- Opcode 0x0000007F → idex_illegal = 1 and reg_write = 0.
